sandbox_host_link: RTL
======================

// Module: sandbox_host_link
// PURPOSE
// Host-side end of the sandbox process handshake: deframes host bytes from the UART receiver into control+data words,
// drives dataReceived/control/inputData to the sandbox process, waits for its transmitData/clearDR handshake,
// then frames status+outputData back into bytes for the UART transmitter. Sits between UART byte I/O and the process.
// PARAMETERS
// RX_SYNC         8'hA5        first byte of every host->FPGA frame
// TX_SYNC         8'h5A        first byte of every FPGA->host frame
// TIMEOUT_CYCLES  24'd1000000  max masterClock cycles between bytes of one rx frame before abort
// PORTS
// masterClock   in   1   operating clock
// reset         in   1   asynchronous, active-low reset
// rxByteValid   in   1   one-cycle strobe: rxByte holds a received byte
// rxByte        in   8   received byte
// txByteReady   in   1   UART transmitter can accept a byte
// txByteValid   out  1   txByte valid; held until accepted
// txByte        out  8   byte to transmit
// dataReceived  out  1   frame available to the process
// control       out  8   received control byte
// inputData     out  32  received data word
// clearDR       in   1   process consumed frame
// transmitData  in   1   process requests transmission (rising edge)
// status        in   8   process status byte
// outputData    in   32  process result word
// frameError    out  1   one-cycle pulse: checksum mismatch or inter-byte timeout
// rxOverrun     out  1   one-cycle pulse: byte dropped (arrived while a frame is held)
// BEHAVIOUR
// - Reset (async, low): all FSMs idle; every output 0; timeout counter and byte index 0.
// - Rx frame: RX_SYNC, control, d[7:0], d[15:8], d[23:16], d[31:24], csum = XOR(control, 4 data bytes). 7 bytes.
// - Rx FSM: R_SYNC -> R_CTRL -> R_DATA(idx 0..3) -> R_CSUM -> R_WAIT -> R_HOLD -> R_SYNC.
//   R_SYNC: non-sync bytes discarded silently. Good csum -> R_WAIT; bad csum -> frameError pulse, R_SYNC.
//   R_WAIT: stays until Tx FSM idle and no capture pending; then dataReceived<=1 next cycle -> R_HOLD.
//   R_HOLD: control/inputData stable; on clearDR==1 -> dataReceived<=0 next cycle, -> R_SYNC.
// - control/inputData updated only on the R_WAIT->R_HOLD transition; never change while dataReceived=1.
// - Timeout: counter runs in R_CTRL..R_CSUM, reloads on every accepted byte; reaching TIMEOUT_CYCLES -> frameError
//   pulse, R_SYNC. A byte arriving in the expiry cycle wins (accepted, counter reloads).
// - Bytes arriving in R_WAIT/R_HOLD are dropped with rxOverrun pulse; no state change.
// - Tx frame: TX_SYNC, status, o[7:0], o[15:8], o[23:16], o[31:24], csum = XOR(status, 4 data bytes).
// - Tx FSM: T_IDLE -> T_SEND(idx 0..6) -> T_IDLE. transmitData 0->1 edge (registered prev) captures status and
//   outputData in that cycle; txByteValid rises next cycle. Byte advances on txByteValid && txByteReady only;
//   txByte stable while txByteValid=1 and not accepted. After idx 6 accepted, txByteValid<=0, T_IDLE.
// - transmitData edge during T_SEND: set pending, capture when T_IDLE re-entered (one-deep; second edge lost).
// - transmitData held high produces exactly one frame; its fall has no effect.
// - Rx and Tx FSMs run concurrently; rx deframing continues while Tx sends.
// - Reset mid-frame: partial rx frame and in-flight tx frame abandoned; txByteValid drops immediately.
// STRUCTURE
// - Package sandbox_link_pkg: RX_SYNC/TX_SYNC defaults, FRAME_LEN=7, rx/tx state encodings, csum function.
// - Sub-module sandbox_link_tx_framer: capture, pending flag, byte index, txByteValid/txByte handshake.
// - Top holds rx deframer, timeout counter, process handshake, R_WAIT gating on framer idle.
// TESTING
// - Rx A5 01 01 02 03 04 05 -> dataReceived=1, control=8'h01, inputData=32'h04030201; clearDR=1 -> dataReceived=0 next cycle.
// - Same frame, csum 8'h06 -> frameError single pulse, dataReceived stays 0; next good frame accepted.
// - status=8'h01, outputData=32'h12345678, transmitData rise, txByteReady=1 -> bytes 5A 01 78 56 34 12 09.
// - txByteReady toggled 1-of-3 cycles during tx -> same 7 bytes, txByte stable while stalled, no dup/skip.
// - A5 01 then silence TIMEOUT_CYCLES (set 16) -> frameError at cycle 16; byte at cycle 16 instead -> no error.
// - Frame held (no clearDR), send 2 more bytes -> two rxOverrun pulses; reset low mid tx -> all outputs 0 at once.

Source files
------------

// File: rtl/sandbox_link_pkg.sv
// Shared framing constants, FSM encodings and checksum helper for the sandbox host link.
package sandbox_link_pkg;

  localparam logic [7:0] RX_SYNC_DEF = 8'hA5;
  localparam logic [7:0] TX_SYNC_DEF = 8'h5A;
  localparam int         FRAME_LEN   = 7;

  typedef enum logic [2:0] {
    R_SYNC,
    R_CTRL,
    R_DATA,
    R_CSUM,
    R_WAIT,
    R_HOLD
  } rx_state_t;

  typedef enum logic {
    T_IDLE,
    T_SEND
  } tx_state_t;

  function automatic logic [7:0] csum(input logic [7:0] hdr, input logic [31:0] dat);
    return hdr ^ dat[7:0] ^ dat[15:8] ^ dat[23:16] ^ dat[31:24];
  endfunction

endpackage

// File: rtl/sandbox_link_tx_framer.sv
// Frames status+result into a 7-byte host frame; captures on a transmit request edge, one-deep pending.
// First byte valid the cycle after capture; bytes advance only on valid&&ready, held stable while stalled.
module sandbox_link_tx_framer
  import sandbox_link_pkg::*;
#(
  parameter logic [7:0] TX_SYNC = TX_SYNC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        transmit_data,
  input  logic [7:0]  status,
  input  logic [31:0] output_data,
  input  logic        tx_rdy,
  output logic        tx_vld,
  output logic [7:0]  tx_dat,
  output logic        busy
);

  tx_state_t   state_q, state_d;
  logic        prev_q, prev_d;
  logic        pending_q, pending_d;
  logic [7:0]  status_cap_q, status_cap_d;
  logic [31:0] data_cap_q, data_cap_d;
  logic [2:0]  idx_q, idx_d;
  logic        vld_q, vld_d;
  logic [7:0]  dat_q, dat_d;
  logic        tx_edge;

  function automatic logic [7:0] byte_at(input logic [2:0] idx, input logic [7:0] st,
                                         input logic [31:0] dat);
    case (idx)
      3'd0:    return TX_SYNC;
      3'd1:    return st;
      3'd2:    return dat[7:0];
      3'd3:    return dat[15:8];
      3'd4:    return dat[23:16];
      3'd5:    return dat[31:24];
      default: return csum(st, dat);
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    prev_d       = transmit_data;
    pending_d    = pending_q;
    status_cap_d = status_cap_q;
    data_cap_d   = data_cap_q;
    idx_d        = idx_q;
    vld_d        = vld_q;
    dat_d        = dat_q;
    tx_edge      = transmit_data && !prev_q;

    case (state_q)
      T_IDLE: begin
        if (tx_edge || pending_q) begin
          status_cap_d = status;
          data_cap_d   = output_data;
          pending_d    = 1'b0;
          idx_d        = 3'd0;
          vld_d        = 1'b1;
          dat_d        = TX_SYNC;
          state_d      = T_SEND;
        end
      end
      default: begin
        // A request arriving mid-frame is remembered once; further edges are lost.
        if (tx_edge) pending_d = 1'b1;
        if (vld_q && tx_rdy) begin
          if (idx_q == 3'(FRAME_LEN - 1)) begin
            vld_d   = 1'b0;
            state_d = T_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
            dat_d = byte_at(idx_q + 3'd1, status_cap_q, data_cap_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= T_IDLE;
      prev_q       <= 1'b0;
      pending_q    <= 1'b0;
      status_cap_q <= '0;
      data_cap_q   <= '0;
      idx_q        <= '0;
      vld_q        <= 1'b0;
      dat_q        <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      status_cap_q <= status_cap_d;
      data_cap_q   <= data_cap_d;
      idx_q        <= idx_d;
      vld_q        <= vld_d;
      dat_q        <= dat_d;
    end
  end

  assign tx_vld = vld_q;
  assign tx_dat = dat_q;
  assign busy   = (state_q == T_SEND) || pending_q || tx_edge;

endmodule

// File: rtl/sandbox_host_link.sv
// Host-side link: deframes host bytes into control+data for the sandbox process and frames its reply.
// Rx frame handed over once the reply framer is idle; bytes arriving while a frame is held are dropped.
module sandbox_host_link
  import sandbox_link_pkg::*;
#(
  parameter logic [7:0]  RX_SYNC        = RX_SYNC_DEF,
  parameter logic [7:0]  TX_SYNC        = TX_SYNC_DEF,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic        masterClock,
  input  logic        reset,
  input  logic        rxByteValid,
  input  logic [7:0]  rxByte,
  input  logic        txByteReady,
  output logic        txByteValid,
  output logic [7:0]  txByte,
  output logic        dataReceived,
  output logic [7:0]  control,
  output logic [31:0] inputData,
  input  logic        clearDR,
  input  logic        transmitData,
  input  logic [7:0]  status,
  input  logic [31:0] outputData,
  output logic        frameError,
  output logic        rxOverrun
);

  rx_state_t   state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  ctrl_sh_q, ctrl_sh_d;
  logic [31:0] data_sh_q, data_sh_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  control_q, control_d;
  logic [31:0] input_data_q, input_data_d;
  logic        data_received_q, data_received_d;
  logic        frame_error_q, frame_error_d;
  logic        rx_overrun_q, rx_overrun_d;
  logic        tx_busy;
  logic        in_frame;
  logic        expired;

  sandbox_link_tx_framer #(
    .TX_SYNC(TX_SYNC)
  ) u_tx (
    .clk          (masterClock),
    .rst_n        (reset),
    .transmit_data(transmitData),
    .status       (status),
    .output_data  (outputData),
    .tx_rdy       (txByteReady),
    .tx_vld       (txByteValid),
    .tx_dat       (txByte),
    .busy         (tx_busy)
  );

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    ctrl_sh_d       = ctrl_sh_q;
    data_sh_d       = data_sh_q;
    control_d       = control_q;
    input_data_d    = input_data_q;
    data_received_d = data_received_q;
    frame_error_d   = 1'b0;
    rx_overrun_d    = 1'b0;

    in_frame = (state_q == R_CTRL) || (state_q == R_DATA) || (state_q == R_CSUM);
    // A byte in the expiry cycle takes priority over the timeout.
    expired  = in_frame && !rxByteValid && ((cnt_q + 24'd1) >= TIMEOUT_CYCLES);
    cnt_d    = (in_frame && !rxByteValid) ? cnt_q + 24'd1 : '0;

    case (state_q)
      R_SYNC: begin
        if (rxByteValid && rxByte == RX_SYNC) state_d = R_CTRL;
      end
      R_CTRL: begin
        if (rxByteValid) begin
          ctrl_sh_d = rxByte;
          idx_d     = 2'd0;
          state_d   = R_DATA;
        end
      end
      R_DATA: begin
        if (rxByteValid) begin
          data_sh_d = {rxByte, data_sh_q[31:8]};
          idx_d     = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = R_CSUM;
        end
      end
      R_CSUM: begin
        if (rxByteValid) begin
          if (rxByte == csum(ctrl_sh_q, data_sh_q)) begin
            state_d = R_WAIT;
          end else begin
            frame_error_d = 1'b1;
            state_d       = R_SYNC;
          end
        end
      end
      R_WAIT: begin
        if (rxByteValid) rx_overrun_d = 1'b1;
        if (!tx_busy) begin
          control_d       = ctrl_sh_q;
          input_data_d    = data_sh_q;
          data_received_d = 1'b1;
          state_d         = R_HOLD;
        end
      end
      R_HOLD: begin
        if (rxByteValid) rx_overrun_d = 1'b1;
        if (clearDR) begin
          data_received_d = 1'b0;
          state_d         = R_SYNC;
        end
      end
      default: state_d = R_SYNC;
    endcase

    if (expired) begin
      frame_error_d = 1'b1;
      state_d       = R_SYNC;
      cnt_d         = '0;
    end
  end

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      state_q         <= R_SYNC;
      idx_q           <= '0;
      ctrl_sh_q       <= '0;
      data_sh_q       <= '0;
      cnt_q           <= '0;
      control_q       <= '0;
      input_data_q    <= '0;
      data_received_q <= 1'b0;
      frame_error_q   <= 1'b0;
      rx_overrun_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      ctrl_sh_q       <= ctrl_sh_d;
      data_sh_q       <= data_sh_d;
      cnt_q           <= cnt_d;
      control_q       <= control_d;
      input_data_q    <= input_data_d;
      data_received_q <= data_received_d;
      frame_error_q   <= frame_error_d;
      rx_overrun_q    <= rx_overrun_d;
    end
  end

  assign dataReceived = data_received_q;
  assign control      = control_q;
  assign inputData    = input_data_q;
  assign frameError   = frame_error_q;
  assign rxOverrun    = rx_overrun_q;

endmodule
